regfile_mp_sb: RTL and testbench

Parametrised multi-port register file for the pipelined core. It adds the following over the single-write, two-read register file:
- N write ports with fixed priority.
- N combinational read ports.
- Optional same-cycle write-to-read bypass.
- Asynchronous clear of all storage.
- A per-register busy scoreboard, set at issue and cleared at writeback.

It sits between decode/issue (reads, scoreboard set) and writeback (write ports).

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/rf_scoreboard.sv | 73 +++++++
 rtl/regfile_mp_sb.sv | 88 ++++++++
 tb/tb_regfile_mp_sb.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared helpers and default types for the multi-port register file and its scoreboard.
package regfile_pkg;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((32'sd1 <<< res) < value) begin
      res = res + 32'sd1;
    end
    return res;
  endfunction

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_ADDRW = clog2(DEF_DEPTH);

  typedef logic [DEF_ADDRW-1:0] addr_t;
  typedef logic [DEF_WIDTH-1:0] data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set at issue, cleared at writeback, looked up by the read ports.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int ADDRW    = clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*ADDRW-1:0] waddr,
  input  logic [NRD*ADDRW-1:0] raddr,
  input  logic                 iss_valid,
  input  logic [ADDRW-1:0]     iss_addr,
  output logic [NRD-1:0]       rbusy,
  output logic [DEPTH-1:0]     busy_vec
);

  logic [DEPTH-1:0] busy_r;
  logic [DEPTH-1:0] set_s;
  logic [DEPTH-1:0] clr_s;
  logic [DEPTH-1:0] busy_next_s;
  logic [NRD-1:0]   hit_s;
  logic [NRD-1:0]   rbusy_s;

  // Set/clear decode and next-state; a new issue beats a same-cycle writeback.
  always_comb begin
    set_s       = '0;
    clr_s       = '0;
    busy_next_s = '0;
    for (int a = 0; a < DEPTH; a++) begin
      set_s[a] = iss_valid && (iss_addr == ADDRW'(a));
      for (int i = 0; i < NWR; i++) begin
        clr_s[a] = clr_s[a] | (we[i] && (waddr[i*ADDRW +: ADDRW] == ADDRW'(a)));
      end
      busy_next_s[a] = set_s[a] | (busy_r[a] & ~clr_s[a]);
    end
    busy_next_s[0] = (ZERO_REG == 1) ? 1'b0 : busy_next_s[0];
  end

  // Busy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_next_s;
    end
  end

  // Read-side busy lookup with optional writeback forwarding.
  always_comb begin
    hit_s   = '0;
    rbusy_s = '0;
    for (int r = 0; r < NRD; r++) begin
      for (int i = 0; i < NWR; i++) begin
        hit_s[r] = hit_s[r] |
                   (we[i] && (waddr[i*ADDRW +: ADDRW] == raddr[r*ADDRW +: ADDRW]));
      end
      rbusy_s[r] = busy_r[raddr[r*ADDRW +: ADDRW]];
      rbusy_s[r] = (BYPASS == 1 && hit_s[r] &&
                    !(iss_valid && iss_addr == raddr[r*ADDRW +: ADDRW])) ? 1'b0 : rbusy_s[r];
      rbusy_s[r] = (ZERO_REG == 1 && raddr[r*ADDRW +: ADDRW] == '0) ? 1'b0 : rbusy_s[r];
    end
  end

  assign rbusy    = rbusy_s;
  assign busy_vec = busy_r;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file: prioritised write ports, combinational reads with optional
// same-cycle bypass, async clear, and a busy scoreboard for issue/writeback tracking.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int ADDRW   = clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*ADDRW-1:0] waddr,
  input  logic [NWR*WIDTH-1:0] wdata,
  input  logic [NRD*ADDRW-1:0] raddr,
  output logic [NRD*WIDTH-1:0] rdata,
  output logic [NRD-1:0]       rbusy,
  input  logic                 iss_valid,
  input  logic [ADDRW-1:0]     iss_addr,
  output logic [DEPTH-1:0]     busy_vec
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [ADDRW-1:0] wa_s  [NWR];
  logic [WIDTH-1:0] wd_s  [NWR];
  logic [ADDRW-1:0] ra_s  [NRD];
  logic [WIDTH-1:0] rd_s  [NRD];

  for (genvar gi = 0; gi < NWR; gi++) begin : g_wr_unpack
    assign wa_s[gi] = waddr[gi*ADDRW +: ADDRW];
    assign wd_s[gi] = wdata[gi*WIDTH +: WIDTH];
  end

  for (genvar gr = 0; gr < NRD; gr++) begin : g_rd_unpack
    assign ra_s[gr]                 = raddr[gr*ADDRW +: ADDRW];
    assign rdata[gr*WIDTH +: WIDTH] = rd_s[gr];
  end

  // Storage; iterating ports upward lets the highest-index port win a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem_r[a] <= '0;
      end
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (we[i] && !(ZERO_REG == 1 && wa_s[i] == '0)) begin
          mem_r[wa_s[i]] <= wd_s[i];
        end
      end
    end
  end

  // Read mux; bypass is held off during reset so rdata stays zero while cleared.
  always_comb begin
    for (int r = 0; r < NRD; r++) begin
      rd_s[r] = mem_r[ra_s[r]];
      for (int i = 0; i < NWR; i++) begin
        rd_s[r] = (BYPASS == 1 && rst_n && we[i] && wa_s[i] == ra_s[r]) ? wd_s[i] : rd_s[r];
      end
      rd_s[r] = (ZERO_REG == 1 && ra_s[r] == '0) ? '0 : rd_s[r];
    end
  end

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS),
    .ADDRW    (ADDRW)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .raddr     (raddr),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .rbusy     (rbusy),
    .busy_vec  (busy_vec)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: bypass and non-bypass instances share stimulus; hand table,
// async-reset sequence, then random traffic against a behavioural model.
module tb_regfile_mp_sb;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [9:0]  raddr;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [63:0] rdata_b, rdata_n;
  logic [1:0]  rbusy_b, rbusy_n;
  logic [31:0] busy_vec_b, busy_vec_n;

  int checks   = 0;
  int failures = 0;

  data_t mem_m  [32];
  logic  busy_m [32];

  always #5 clk = ~clk;

  regfile_mp_sb #(.BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_b), .rbusy(rbusy_b), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .busy_vec(busy_vec_b));

  regfile_mp_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_n), .rbusy(rbusy_n), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .busy_vec(busy_vec_n));

  typedef struct {
    logic [1:0] we;
    addr_t      wa0, wa1;
    data_t      wd0, wd1;
    addr_t      ra0;
    logic       iv;
    addr_t      ia;
    data_t      e_rd_b, e_rd_n;
    logic       e_rb_b, e_rb_n;
    logic [31:0] e_bv;
  } vec_t;

  vec_t tv [16];

  function automatic vec_t mk(input logic [1:0] w, input addr_t a0, input addr_t a1,
                              input data_t d0, input data_t d1, input addr_t r0,
                              input logic v, input addr_t ia, input data_t erb,
                              input data_t ern, input logic ebb, input logic ebn,
                              input logic [31:0] ebv);
    vec_t t;
    t.we = w; t.wa0 = a0; t.wa1 = a1; t.wd0 = d0; t.wd1 = d1; t.ra0 = r0;
    t.iv = v; t.ia = ia; t.e_rd_b = erb; t.e_rd_n = ern; t.e_rb_b = ebb;
    t.e_rb_n = ebn; t.e_bv = ebv;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic wr_hit(input addr_t a);
    for (int i = 0; i < 2; i++) begin
      if (we[i] && waddr[i*5 +: 5] == a) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Reference read: zero register, else youngest same-cycle writer (bypass), else memory.
  function automatic data_t exp_rd(input addr_t a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp) begin
      for (int i = 1; i >= 0; i--) begin
        if (we[i] && waddr[i*5 +: 5] == a) return wdata[i*32 +: 32];
      end
    end
    return mem_m[a];
  endfunction

  function automatic logic exp_rb(input addr_t a, input bit byp);
    if (a == 5'd0) return 1'b0;
    if (byp && wr_hit(a) && !(iss_valid && iss_addr == a)) return 1'b0;
    return busy_m[a];
  endfunction

  function automatic logic [31:0] busy_word();
    logic [31:0] w;
    for (int a = 0; a < 32; a++) w[a] = busy_m[a];
    return w;
  endfunction

  task automatic model_edge();
    logic nb [32];
    for (int a = 0; a < 32; a++) begin
      nb[a] = (iss_valid && iss_addr == a[4:0]) || (busy_m[a] && !wr_hit(a[4:0]));
    end
    nb[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (we[i] && waddr[i*5 +: 5] != 5'd0) mem_m[waddr[i*5 +: 5]] = wdata[i*32 +: 32];
    end
    for (int a = 0; a < 32; a++) busy_m[a] = nb[a];
  endtask

  task automatic model_clear();
    for (int a = 0; a < 32; a++) begin
      mem_m[a]  = 32'd0;
      busy_m[a] = 1'b0;
    end
  endtask

  task automatic check_model();
    for (int r = 0; r < 2; r++) begin
      chk("rdata_byp", {32'd0, rdata_b[r*32 +: 32]}, {32'd0, exp_rd(raddr[r*5 +: 5], 1'b1)});
      chk("rdata_nb",  {32'd0, rdata_n[r*32 +: 32]}, {32'd0, exp_rd(raddr[r*5 +: 5], 1'b0)});
      chk("rbusy_byp", {63'd0, rbusy_b[r]}, {63'd0, exp_rb(raddr[r*5 +: 5], 1'b1)});
      chk("rbusy_nb",  {63'd0, rbusy_n[r]}, {63'd0, exp_rb(raddr[r*5 +: 5], 1'b0)});
    end
    chk("busy_vec_byp", {32'd0, busy_vec_b}, {32'd0, busy_word()});
    chk("busy_vec_nb",  {32'd0, busy_vec_n}, {32'd0, busy_word()});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; we = 2'b00; waddr = '0; wdata = '0; raddr = '0;
    iss_valid = 1'b0; iss_addr = 5'd0;
    model_clear();

    tv[0]  = mk(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd5, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0);
    tv[1]  = mk(2'b01, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'd0, 5'd5, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 32'h0);
    tv[2]  = mk(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd5, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    tv[3]  = mk(2'b11, 5'd7, 5'd7, 32'd1, 32'd2, 5'd7, 1'b0, 5'd0, 32'd2, 32'd0, 1'b0, 1'b0, 32'h0);
    tv[4]  = mk(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd7, 1'b0, 5'd0, 32'd2, 32'd2, 1'b0, 1'b0, 32'h0);
    tv[5]  = mk(2'b01, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 5'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0);
    tv[6]  = mk(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0);
    tv[7]  = mk(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd9, 1'b1, 5'd9, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0);
    tv[8]  = mk(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd9, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h200);
    tv[9]  = mk(2'b01, 5'd9, 5'd0, 32'h99, 32'd0, 5'd9, 1'b0, 5'd0, 32'h99, 32'd0, 1'b0, 1'b1, 32'h200);
    tv[10] = mk(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd9, 1'b0, 5'd0, 32'h99, 32'h99, 1'b0, 1'b0, 32'h0);
    tv[11] = mk(2'b01, 5'd9, 5'd0, 32'hAA, 32'd0, 5'd9, 1'b1, 5'd9, 32'hAA, 32'h99, 1'b0, 1'b0, 32'h0);
    tv[12] = mk(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd9, 1'b0, 5'd0, 32'hAA, 32'hAA, 1'b1, 1'b1, 32'h200);
    tv[13] = mk(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h200);
    tv[14] = mk(2'b01, 5'd9, 5'd0, 32'hBB, 32'd0, 5'd9, 1'b1, 5'd9, 32'hBB, 32'hAA, 1'b1, 1'b1, 32'h200);
    tv[15] = mk(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd9, 1'b0, 5'd0, 32'hBB, 32'hBB, 1'b1, 1'b1, 32'h200);

    // Reset held for two cycles; outputs must read clear.
    raddr = {5'd0, 5'd5};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata", rdata_b, 64'd0);
    chk("reset_rbusy", {62'd0, rbusy_b}, 64'd0);
    chk("reset_busy_vec", {32'd0, busy_vec_b}, 64'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      we = tv[k].we;
      waddr = {tv[k].wa1, tv[k].wa0};
      wdata = {tv[k].wd1, tv[k].wd0};
      raddr = {5'd0, tv[k].ra0};
      iss_valid = tv[k].iv;
      iss_addr = tv[k].ia;
      #2;
      chk($sformatf("tv%0d_rd_byp", k), {32'd0, rdata_b[31:0]}, {32'd0, tv[k].e_rd_b});
      chk($sformatf("tv%0d_rd_nb", k), {32'd0, rdata_n[31:0]}, {32'd0, tv[k].e_rd_n});
      chk($sformatf("tv%0d_rbusy_byp", k), {63'd0, rbusy_b[0]}, {63'd0, tv[k].e_rb_b});
      chk($sformatf("tv%0d_rbusy_nb", k), {63'd0, rbusy_n[0]}, {63'd0, tv[k].e_rb_n});
      chk($sformatf("tv%0d_busy_vec", k), {32'd0, busy_vec_b}, {32'd0, tv[k].e_bv});
      tick();
    end

    // Async reset between edges while a write and an issue are presented.
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'd0, 32'h33};
    iss_valid = 1'b1; iss_addr = 5'd4; raddr = {5'd7, 5'd9};
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy_vec", {32'd0, busy_vec_b}, 64'd0);
    chk("arst_rdata_byp", rdata_b, 64'd0);
    chk("arst_rdata_nb", rdata_n, 64'd0);
    @(posedge clk);
    #1;
    model_clear();
    rst_n = 1'b1; we = 2'b00; iss_valid = 1'b0; raddr = {5'd4, 5'd3};
    #2;
    chk("arst_write_lost", {32'd0, rdata_n[31:0]}, 64'd0);
    check_model();
    tick();

    // Random traffic on a narrow address range to force collisions and hazards.
    for (int n = 0; n < 400; n++) begin
      we = 2'($urandom_range(0, 3));
      waddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wdata = {$urandom, $urandom};
      raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      iss_valid = 1'($urandom_range(0, 1));
      iss_addr = 5'($urandom_range(0, 7));
      #2;
      check_model();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
